bootdata_byte_streamer: RTL

- Converts the control module's 32-bit boot-data word stream (req/ack handshake) into a byte stream with valid/ready for the iNES game loader.
- Replaces the dual-clock FIFO plus derived loader clocks with a single-clock unpacker that runs on the core clock.
- Enforces the ROM-size limit and, optionally, header synchronisation.
- Sits between CtrlModule's host_bootdata* outputs and GameLoader's byte input.

---
 rtl/bootdata_pkg.sv | 19 +
 rtl/bootdata_byte_streamer_if.sv | 14 +
 rtl/bootdata_byte_streamer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bootdata_pkg.sv
// Shared types and helpers for the boot-data word-to-byte streamer.
package bootdata_pkg;

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [7:0] HDR_SYNC_BYTE = 8'h4E;
  localparam int unsigned MAX_WORD_W = 128;
  localparam int unsigned LANE_W = 4;

  // Byte `lane` of a word holding `lanes` bytes, lane 0 being the most significant.
  function automatic logic [7:0] byte_of(input logic [MAX_WORD_W-1:0] word,
                                         input int unsigned lanes,
                                         input logic [LANE_W-1:0] lane);
    int unsigned sh;
    sh = 8 * (lanes - 1 - 32'(lane));
    return 8'(word >> sh);
  endfunction

endpackage

// File: rtl/bootdata_byte_streamer_if.sv
// Word request/ack side and byte valid/ready side of the boot-data streamer.
interface bootdata_byte_streamer_if #(parameter int unsigned WORD_W = 32);
  logic [WORD_W-1:0] bootdata;
  logic              bootdata_req;
  logic              bootdata_ack;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (input  bootdata, bootdata_req, byte_ready,
                  output bootdata_ack, byte_data, byte_valid);
  modport slave  (output bootdata, bootdata_req, byte_ready,
                  input  bootdata_ack, byte_data, byte_valid);
endinterface

// File: rtl/bootdata_byte_streamer.sv
// Single-clock unpacker from host boot-data words to a byte stream for the game loader.
// Optional header synchronisation on the first 8'h4E is enabled by BOOTDATA_HDR_SYNC_EN.
module bootdata_byte_streamer
  import bootdata_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          rom_size,
  bootdata_byte_streamer_if.master  bus,
  output logic [CNT_W-1:0]          byte_count,
  output logic                      done
);

  localparam int unsigned        LANES     = WORD_W / 8;
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [CNT_W-1:0]   offset_q, offset_d;
  logic [CNT_W-1:0]   rom_q, rom_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               armed_q, armed_d;
  logic               ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [7:0]         data_q, data_d;
  logic               lane_done;
  logic [7:0]         nxt_byte;

`ifdef BOOTDATA_HDR_SYNC_EN
  logic synced_q, synced_d;
`else
  logic synced_d;
  assign synced_d = 1'b1;
`endif

  assign bus.bootdata_ack = ack_q;
  assign bus.byte_valid   = valid_q;
  assign bus.byte_data    = data_q;
  assign byte_count       = count_q;
  assign done             = done_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      lane_q   <= '0;
      offset_q <= '0;
      rom_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      armed_q  <= 1'b1;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
`ifdef BOOTDATA_HDR_SYNC_EN
      synced_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      lane_q   <= lane_d;
      offset_q <= offset_d;
      rom_q    <= rom_d;
      count_q  <= count_d;
      done_q   <= done_d;
      armed_q  <= armed_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
`ifdef BOOTDATA_HDR_SYNC_EN
      synced_q <= synced_d;
`endif
    end
  end

  // Next state; byte_valid/byte_data are precomputed for the lane presented next cycle
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    lane_d    = lane_q;
    offset_d  = offset_q;
    rom_d     = rom_q;
    count_d   = count_q;
    done_d    = done_q;
    armed_d   = armed_q;
    ack_d     = 1'b0;
    valid_d   = 1'b0;
    data_d    = data_q;
    lane_done = 1'b0;
    nxt_byte  = '0;
`ifdef BOOTDATA_HDR_SYNC_EN
    synced_d  = synced_q;
`endif

    if (!bus.bootdata_req) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.bootdata_req && armed_q) begin
          word_d  = bus.bootdata;
          lane_d  = '0;
          state_d = EMIT;
          ack_d   = 1'b1;
          armed_d = 1'b0;
        end
      end
      EMIT: begin
        // A dropped lane (valid low) completes without a handshake
        lane_done = !valid_q || bus.byte_ready;
        if (lane_done) begin
          offset_d = (offset_q == CNT_MAX) ? offset_q : offset_q + CNT_W'(1);
          if (valid_q) begin
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
`ifdef BOOTDATA_HDR_SYNC_EN
            if (data_q == HDR_SYNC_BYTE) synced_d = 1'b1;
`endif
          end
          if (offset_d == rom_q) done_d = 1'b1;
          if (lane_q == LAST_LANE) state_d = IDLE;
          else                     lane_d  = lane_q + LANE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == EMIT) begin
      nxt_byte = byte_of(MAX_WORD_W'(word_d), LANES, lane_d);
      data_d   = nxt_byte;
      valid_d  = (offset_d < rom_q) && (synced_d || nxt_byte == HDR_SYNC_BYTE);
    end

    // Session clear wins over everything and latches the new file length
    if (start) begin
      state_d  = IDLE;
      lane_d   = '0;
      offset_d = '0;
      rom_d    = rom_size;
      count_d  = '0;
      done_d   = 1'b0;
      armed_d  = 1'b1;
      ack_d    = 1'b0;
      valid_d  = 1'b0;
      data_d   = '0;
`ifdef BOOTDATA_HDR_SYNC_EN
      synced_d = 1'b0;
`endif
    end
  end

endmodule
